// File: rtl/mac_stream.sv
// Handshaked multi-lane fixed-point dot-product MAC with backpressure-frozen pipeline.
// Define MAC_STREAM_SAT_EN for saturating accumulation and the per-packet r_ovf flag.
module mac_stream #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 4,
  parameter int MUL_LAT = 2,
  parameter int ACC_W   = 40
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [LANES*DATA_W-1:0]   a_tdata,
  input  logic [LANES*DATA_W-1:0]   b_tdata,
  input  logic                      a_tvalid,
  input  logic                      a_tlast,
  output logic                      a_tready,
  output logic signed [ACC_W-1:0]   r_tdata,
  output logic                      r_tvalid,
  output logic                      r_tlast,
  input  logic                      r_tready,
  output logic                      r_ovf
);

  localparam int PROD_W = 2 * DATA_W;

  if (ACC_W < 2 * DATA_W + $clog2(LANES)) begin : g_bad_acc_w
    $error("mac_stream: ACC_W must be at least 2*DATA_W + clog2(LANES)");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("mac_stream: LANES must be in 1..16");
  end
  if (MUL_LAT < 1 || MUL_LAT > 4) begin : g_bad_mul_lat
    $error("mac_stream: MUL_LAT must be in 1..4");
  end

`ifdef MAC_STREAM_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic logic acc_clip(input logic signed [ACC_W-1:0] x,
                                    input logic signed [ACC_W-1:0] y);
    logic signed [ACC_W-1:0] s;
    s = x + y;
    return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] x,
                                                      input logic signed [ACC_W-1:0] y);
    if (acc_clip(x, y)) return x[ACC_W-1] ? ACC_MIN : ACC_MAX;
    return x + y;
  endfunction
`else
  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] x,
                                                      input logic signed [ACC_W-1:0] y);
    return x + y;
  endfunction
`endif

  logic en;
  assign en       = !(r_tvalid && !r_tready);
  assign a_tready = en;
  assign r_tlast  = r_tvalid;

  // Stage p0: operand capture
  logic signed [DATA_W-1:0] a_p0 [LANES];
  logic signed [DATA_W-1:0] b_p0 [LANES];
  logic                     vld_p0, last_p0;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else if (en) begin
      vld_p0  <= a_tvalid;
      last_p0 <= a_tlast;
    end
  end

  always_ff @(posedge aclk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        a_p0[i] <= a_tdata[i*DATA_W +: DATA_W];
        b_p0[i] <= b_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stages P1..P_MUL_LAT: lane products, index s holds stage s+1
  logic signed [PROD_W-1:0] prod_pm [MUL_LAT][LANES];
  logic [MUL_LAT-1:0]       vld_pm, last_pm;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_pm  <= '0;
      last_pm <= '0;
    end else if (en) begin
      vld_pm[0]  <= vld_p0;
      last_pm[0] <= last_p0;
      for (int s = 1; s < MUL_LAT; s++) begin
        vld_pm[s]  <= vld_pm[s-1];
        last_pm[s] <= last_pm[s-1];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        prod_pm[0][i] <= PROD_W'(a_p0[i]) * PROD_W'(b_p0[i]);
      end
      for (int s = 1; s < MUL_LAT; s++) begin
        prod_pm[s] <= prod_pm[s-1];
      end
    end
  end

  // Stage S: registered lane sum, sign-extended to the accumulator width
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] sum_s;
  logic                    vld_s, last_s;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + ACC_W'(prod_pm[MUL_LAT-1][i]);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_s  <= 1'b0;
      last_s <= 1'b0;
    end else if (en) begin
      vld_s  <= vld_pm[MUL_LAT-1];
      last_s <= last_pm[MUL_LAT-1];
    end
  end

  always_ff @(posedge aclk) begin
    if (en) sum_s <= lane_sum;
  end

  // Stage C: accumulate, emit on last, clear so the next packet starts from zero
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;

  assign acc_next = acc_add(acc, sum_s);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc      <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else if (en) begin
      if (vld_s && last_s) begin
        r_tdata  <= acc_next;
        r_tvalid <= 1'b1;
        acc      <= '0;
      end else begin
        r_tvalid <= 1'b0;
        if (vld_s) acc <= acc_next;
      end
    end
  end

`ifdef MAC_STREAM_SAT_EN
  logic ovf_acc;
  logic clip_c;

  assign clip_c = acc_clip(acc, sum_s);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ovf_acc <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (en && vld_s) begin
      if (last_s) begin
        r_ovf   <= ovf_acc | clip_c;
        ovf_acc <= 1'b0;
      end else begin
        ovf_acc <= ovf_acc | clip_c;
      end
    end
  end
`else
  assign r_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_stream.sv
// Scoreboard bench for mac_stream: a 4-lane instance for streaming behaviour and a
// narrow 2-lane instance (ACC_W=33) for overflow handling in either build.
`timescale 1ns/1ps
module tb_mac_stream;
  localparam int DATA_W = 16, LANES = 4, MUL_LAT = 2, ACC_W = 40;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [LANES*DATA_W-1:0] a_tdata = '0, b_tdata = '0;
  logic a_tvalid = 1'b0, a_tlast = 1'b0, r_tready = 1'b1;
  logic a_tready, r_tvalid, r_tlast, r_ovf;
  logic signed [ACC_W-1:0] r_tdata;

  mac_stream #(.DATA_W(DATA_W), .LANES(LANES), .MUL_LAT(MUL_LAT), .ACC_W(ACC_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .a_tdata(a_tdata), .b_tdata(b_tdata),
    .a_tvalid(a_tvalid), .a_tlast(a_tlast), .a_tready(a_tready),
    .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tlast(r_tlast),
    .r_tready(r_tready), .r_ovf(r_ovf));

  logic [31:0] a2_tdata = '0, b2_tdata = '0;
  logic a2_tvalid = 1'b0, a2_tlast = 1'b0, r2_tready = 1'b1;
  logic a2_tready, r2_tvalid, r2_tlast, r2_ovf;
  logic signed [32:0] r2_tdata;

  mac_stream #(.DATA_W(16), .LANES(2), .MUL_LAT(1), .ACC_W(33)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .a_tdata(a2_tdata), .b_tdata(b2_tdata),
    .a_tvalid(a2_tvalid), .a_tlast(a2_tlast), .a_tready(a2_tready),
    .r_tdata(r2_tdata), .r_tvalid(r2_tvalid), .r_tlast(r2_tlast),
    .r_tready(r2_tready), .r_ovf(r2_ovf));

  int chk = 0, pass = 0;
  int mchk = 0, mpass = 0, m2chk = 0, m2pass = 0;
  int n_pushed = 0, n_seen = 0;
  bit rand_bp = 1'b0;
  logic signed [ACC_W-1:0] exp_q[$];
  logic signed [ACC_W-1:0] mexp;
  logic [33:0] exp2_q[$];
  logic [33:0] m2exp;

  function automatic logic [63:0] pk(input int x0, input int x1, input int x2, input int x3);
    return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction

  function automatic longint dot(input logic [63:0] a, input logic [63:0] b);
    longint s = 0;
    for (int i = 0; i < 4; i++)
      s += longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
    return s;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    chk++;
    if (act == req) pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic expect_result(input longint v);
    exp_q.push_back(ACC_W'(v));
    n_pushed++;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rand_bp) r_tready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic last);
    bit took;
    a_tdata = a; b_tdata = b; a_tvalid = 1'b1; a_tlast = last;
    for (int k = 0; k < 200; k++) begin
      @(negedge aclk);
      took = a_tready;
      tick();
      if (took) return;
    end
    chk++;
    $display("FAIL send: a_tready stayed low for 200 cycles");
  endtask

  task automatic idle(input int n);
    a_tvalid = 1'b0; a_tlast = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && (exp_q.size() != 0 || exp2_q.size() != 0); k++) tick();
    check("drain_q1", exp_q.size(), 0);
    check("drain_q2", exp2_q.size(), 0);
  endtask

  always @(negedge aclk) begin
    if (aresetn && r_tvalid && r_tready) begin
      mchk++; n_seen++;
      if (exp_q.size() == 0) begin
        $display("FAIL result: unexpected r_tdata=%0d", r_tdata);
      end else begin
        mexp = exp_q.pop_front();
        if (r_tdata == mexp && r_tlast && !r_ovf) mpass++;
        else $display("FAIL result: got %0d last=%0b ovf=%0b, expected %0d last=1 ovf=0",
                      r_tdata, r_tlast, r_ovf, mexp);
      end
    end
  end

  always @(negedge aclk) begin
    if (aresetn && r2_tvalid && r2_tready) begin
      m2chk++;
      if (exp2_q.size() == 0) begin
        $display("FAIL result2: unexpected r_tdata=%0d", r2_tdata);
      end else begin
        m2exp = exp2_q.pop_front();
        if ({r2_ovf, r2_tdata} == m2exp && r2_tlast) m2pass++;
        else $display("FAIL result2: got %0d ovf=%0b, expected %0d ovf=%0b",
                      r2_tdata, r2_ovf, $signed(m2exp[32:0]), m2exp[33]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    longint total;
    int nb;
    logic [63:0] ra, rb;

    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    check("rst_tvalid", r_tvalid, 0);
    check("rst_tdata", r_tdata, 0);
    check("rst_tlast", r_tlast, 0);
    check("rst_ovf", r_ovf, 0);
    check("rst_tready", a_tready, 1);

    // single beat, latency
    expect_result(70);
    send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b1);
    a_tvalid = 1'b0; a_tlast = 1'b0;
    lat = 0;
    while (!r_tvalid && lat < 20) begin
      @(posedge aclk); #1; lat++;
    end
    check("latency", lat, MUL_LAT + 2);
    idle(2);

    // multi-beat packet followed immediately by new packets
    expect_result(-1200);
    for (int i = 0; i < 3; i++) send(pk(-1, -1, -1, -1), pk(100, 100, 100, 100), i == 2);
    expect_result(70);
    send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b1);
    expect_result(8);
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0);
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b1);
    idle(8);

    // backpressure with two results in flight
    r_tready = 1'b0;
    expect_result(10);
    send(pk(1, 1, 1, 1), pk(1, 2, 3, 4), 1'b1);
    expect_result(18);
    send(pk(-3, 5, 7, 0), pk(2, 2, 2, 2), 1'b1);
    a_tvalid = 1'b0; a_tlast = 1'b0;
    lat = 0;
    while (!r_tvalid && lat < 20) begin
      @(posedge aclk); #1; lat++;
    end
    check("stall_start", r_tvalid, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_tready", a_tready, 0);
      check("stall_hold", r_tdata, 10);
      @(posedge aclk); #1;
    end
    r_tready = 1'b1;
    idle(10);

    // random packets with bubbles and backpressure
    rand_bp = 1'b1;
    for (int p = 0; p < 100; p++) begin
      nb = $urandom_range(1, 4);
      total = 0;
      for (int bt = 0; bt < nb; bt++) begin
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        total += dot(ra, rb);
        if (bt == nb - 1) expect_result(total);
        send(ra, rb, bt == nb - 1);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
    end
    a_tvalid = 1'b0; a_tlast = 1'b0;
    rand_bp = 1'b0; r_tready = 1'b1;
    drain();
    check("packet_count", n_seen, n_pushed);

    // reset mid-packet discards the partial sum
    send(pk(5, 5, 5, 5), pk(5, 5, 5, 5), 1'b0);
    send(pk(5, 5, 5, 5), pk(5, 5, 5, 5), 1'b0);
    a_tvalid = 1'b0;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("mid_rst_tvalid", r_tvalid, 0);
    check("mid_rst_tdata", r_tdata, 0);
    check("mid_rst_tlast", r_tlast, 0);
    check("mid_rst_ovf", r_ovf, 0);
    aresetn = 1'b1;
    check("mid_rst_tready", a_tready, 1);
    expect_result(24);
    send(pk(2, 2, 2, 2), pk(3, 3, 3, 3), 1'b1);
    idle(8);

    // narrow accumulator: two beats of max-positive products, then a small packet
`ifdef MAC_STREAM_SAT_EN
    exp2_q.push_back({1'b1, 1'b0, 32'hFFFF_FFFF});
`else
    exp2_q.push_back({1'b0, 1'b1, 32'h0000_0000});
`endif
    exp2_q.push_back({1'b0, 33'd2});
    a2_tdata = 32'h8000_8000; b2_tdata = 32'h8000_8000;
    a2_tvalid = 1'b1; a2_tlast = 1'b0;
    @(posedge aclk); #1;
    a2_tlast = 1'b1;
    @(posedge aclk); #1;
    a2_tdata = 32'h0001_0001; b2_tdata = 32'h0001_0001;
    @(posedge aclk); #1;
    a2_tvalid = 1'b0; a2_tlast = 1'b0;
    idle(8);
    drain();

    $display("%0d/%0d checks passed", pass + mpass + m2pass, chk + mchk + m2chk);
    $finish;
  end
endmodule

// File: doc/mac_stream.md
# mac_stream

Parametrised, fully handshaked fixed-point multiply-accumulate engine: the integer successor to the single-lane half-precision MAC. Each accepted beat carries LANES signed operand pairs. Their products are summed and accumulated until a beat marked `a_tlast`, at which point the dot-product result is emitted on an AXI-stream-style output and the accumulator clears. The block sits between operand streamers and result write-back in the generated HLS datapath and replaces free-running MACs that have no backpressure.

## Interface
- `DATA_W`, 16: signed operand width per lane.
- `LANES`, 4: operand pairs per beat, range 1..16.
- `MUL_LAT`, 2: product pipeline register stages, range 1..4.
- `ACC_W`, 40: accumulator and result width. Must be ≥ 2·DATA_W + clog2(LANES); violation is an elaboration error.
- `aclk`  in  1: sole clock, rising edge.
- `aresetn`  in  1: reset, synchronous, active-low.
- `a_tdata`  in  LANES·DATA_W: lane i at bits [i·DATA_W +: DATA_W], signed.
- `b_tdata`  in  LANES·DATA_W: same packing as `a_tdata`.
- `a_tvalid`  in  1: input beat valid.
- `a_tlast`  in  1: final beat of the current dot product.
- `a_tready`  out  1: input beat accepted when `a_tvalid && a_tready`.
- `r_tdata`  out  ACC_W: signed dot-product result.
- `r_tvalid`  out  1: result valid.
- `r_tlast`  out  1: equals `r_tvalid`; every result is a single-beat packet.
- `r_tready`  in  1: downstream accepts result.
- `r_ovf`  out  1: accumulation of this result overflowed (see Configuration).

## Operation
- Pipeline stages: P1..P_MUL_LAT (lane products, 2·DATA_W signed), S (registered lane-sum), C (accumulate/output). Each stage carries a valid bit and a last bit.
- Global advance enable `en = !(r_tvalid && !r_tready)`. When `en` is low, every stage, the accumulator, and the outputs hold.
- `a_tready = en`. This is combinational from `r_tready`; no other dependency.
- Stage C, on a valid S entry:
  - Not last: `acc <= acc + sum`.
  - Last: `r_tdata <= acc + sum`, `r_tvalid <= 1`, `acc <= 0`.
- When `en` is high and no last entry reaches C, `r_tvalid <= 0` (the result was consumed).
- Arithmetic: full-precision signed products. The lane sum is sign-extended to ACC_W. The accumulator is two's-complement ACC_W.
- Bubbles (`a_tvalid` low) propagate as invalid entries and do not disturb `acc`.
- Single-beat dot product (`a_tlast` on the first beat) yields the bare lane sum.
- Back-to-back packets: the first beat of packet N+1 may be accepted in the cycle after the last beat of packet N. The accumulator clear and the new-packet add never merge.
- Reset, including mid-packet or with a result pending: all valid bits 0, `acc = 0`, `r_tdata = 0`, `r_tvalid = 0`, `r_tlast = 0`, `r_ovf = 0`. Partial sums are discarded. `a_tready` reads 1 in the first cycle after reset release.

## Timing
- Latency: last beat accepted at edge t gives `r_tvalid` high after edge t + MUL_LAT + 2, with no stall.
- Throughput: one beat per cycle while `r_tready` stays high or no result is pending.
- A stall cycle (`r_tvalid && !r_tready`) freezes the whole pipeline for exactly that cycle. No beat is lost or duplicated, and `r_tdata` is stable while held.
- Result handed off and new result arriving in the same cycle: `r_tvalid` stays high and `r_tdata` updates on that edge.

## Configuration
- `MAC_STREAM_SAT_EN` defined:
  - Every accumulator add saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - `r_ovf` is a per-packet sticky flag set when any add in that packet clipped.
  - `r_ovf` is presented with the result and cleared alongside `acc`.
- Not defined:
  - Adds wrap modulo 2^ACC_W.
  - `r_ovf` is tied to 0.
  - The saturation logic is not synthesised.

## Test plan
- LANES=4, DATA_W=16: a={1,2,3,4}, b={5,6,7,8} with tlast on a single beat → `r_tdata`=70, `r_tvalid` high exactly MUL_LAT+2 cycles after acceptance.
- Three-beat packet a={−1,−1,−1,−1}, b={100,…} per beat, `r_tready`=1 → one result of −1200. The next packet is accepted immediately and starts from 0.
- `r_tready` held low for 5 cycles with two packets in flight → `a_tready` low for those 5 cycles, first result held stable, then both results delivered in order with correct values.
- Random `a_tvalid` bubbles (50%) over 100 random packets vs. scoreboard → bit-exact results, correct packet count.
- `aresetn` low for one cycle mid-packet → all outputs 0. The following packet a={2,…}, b={3,…}, single beat → 24 (no stale partial sum).
- ACC_W=33, DATA_W=16, LANES=2, repeated max-positive products: with `MAC_STREAM_SAT_EN` → 2^32−1 and `r_ovf`=1; without it → wrapped value and `r_ovf`=0.
